// File: rtl/clock_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clock_pkg : shared constants for the time display (FSM states, segments) |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
package clock_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_CONV_H = 3'd2;
    localparam logic [2:0] ST_CONV_M = 3'd3;
    localparam logic [2:0] ST_CONV_S = 3'd4;
    localparam logic [2:0] ST_COMMIT = 3'd5;

    // Active-low codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam int DIG_H10 = 5;
    localparam int DIG_H1  = 4;
    localparam int DIG_M10 = 3;
    localparam int DIG_M1  = 2;
    localparam int DIG_S10 = 1;
    localparam int DIG_S1  = 0;

    localparam logic [2:0] COLON_LO = 3'd2;
    localparam logic [2:0] COLON_HI = 3'd4;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_decode : 4-bit digit to active-low 7-segment code, blank above 9    |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module seg7_decode
    import clock_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] code
);

    always_comb begin
        code = SEG_BLANK;
        case (digit)
            4'd0: code = SEG_0;
            4'd1: code = SEG_1;
            4'd2: code = SEG_2;
            4'd3: code = SEG_3;
            4'd4: code = SEG_4;
            4'd5: code = SEG_5;
            4'd6: code = SEG_6;
            4'd7: code = SEG_7;
            4'd8: code = SEG_8;
            4'd9: code = SEG_9;
            default: code = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/time_display_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | time_display_scan : binary h/m/s -> BCD buffer -> 6-digit muxed display  |
// | Revision          : 1.0                                                  |
// +--------------------------------------------------------------------------+
module time_display_scan
    import clock_pkg::*;
#(
    parameter int P_HOUR_BIT = 5,
    parameter int P_MIN_BIT  = 6,
    parameter int P_SEC_BIT  = 6,
    parameter int P_SCAN_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [P_HOUR_BIT-1:0] hour,
    input  logic [P_MIN_BIT-1:0]  minute,
    input  logic [P_SEC_BIT-1:0]  second,
    input  logic                  update,
    output logic                  busy,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [5:0]            an
);

    localparam int CNT_W = (P_SCAN_DIV > 1) ? $clog2(P_SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(P_SCAN_DIV - 1);
    localparam logic [P_HOUR_BIT-1:0] TEN_H    = P_HOUR_BIT'(10);
    localparam logic [P_MIN_BIT-1:0]  TEN_M    = P_MIN_BIT'(10);
    localparam logic [P_SEC_BIT-1:0]  TEN_S    = P_SEC_BIT'(10);

    logic [2:0]            r_state;
    logic                  r_pending;
    logic [P_HOUR_BIT-1:0] r_rem_h;
    logic [P_MIN_BIT-1:0]  r_rem_m;
    logic [P_SEC_BIT-1:0]  r_rem_s;
    logic [2:0]            r_tens_h;
    logic [2:0]            r_tens_m;
    logic [2:0]            r_tens_s;
    logic [3:0]            r_buf [6];
    logic                  r_colon_on;

    logic [CNT_W-1:0]      r_scan_cnt;
    logic [2:0]            r_idx;
    logic [3:0]            w_digit;
    logic [6:0]            w_seg_code;

    assign busy = (r_state != ST_IDLE);

    // Working remainders/tens are private; the buffer is touched only in COMMIT
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pending  <= 1'b1;
            r_rem_h    <= '0;
            r_rem_m    <= '0;
            r_rem_s    <= '0;
            r_tens_h   <= '0;
            r_tens_m   <= '0;
            r_tens_s   <= '0;
            r_colon_on <= 1'b0;
            for (int i = 0; i < 6; i++) r_buf[i] <= '0;
        end else begin
            if (update && (r_state != ST_IDLE)) r_pending <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (update || r_pending) begin
                        r_state   <= ST_LOAD;
                        r_pending <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_rem_h  <= hour;
                    r_rem_m  <= minute;
                    r_rem_s  <= second;
                    r_tens_h <= '0;
                    r_tens_m <= '0;
                    r_tens_s <= '0;
                    r_state  <= ST_CONV_H;
                end
                ST_CONV_H: begin
                    if (r_rem_h >= TEN_H) begin
                        r_rem_h  <= r_rem_h - TEN_H;
                        r_tens_h <= r_tens_h + 3'd1;
                    end else begin
                        r_state <= ST_CONV_M;
                    end
                end
                ST_CONV_M: begin
                    if (r_rem_m >= TEN_M) begin
                        r_rem_m  <= r_rem_m - TEN_M;
                        r_tens_m <= r_tens_m + 3'd1;
                    end else begin
                        r_state <= ST_CONV_S;
                    end
                end
                ST_CONV_S: begin
                    if (r_rem_s >= TEN_S) begin
                        r_rem_s  <= r_rem_s - TEN_S;
                        r_tens_s <= r_tens_s + 3'd1;
                    end else begin
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    r_buf[DIG_H10] <= {1'b0, r_tens_h};
                    r_buf[DIG_H1]  <= 4'(r_rem_h);
                    r_buf[DIG_M10] <= {1'b0, r_tens_m};
                    r_buf[DIG_M1]  <= 4'(r_rem_m);
                    r_buf[DIG_S10] <= {1'b0, r_tens_s};
                    r_buf[DIG_S1]  <= 4'(r_rem_s);
                    r_colon_on     <= ~r_colon_on;
                    r_state        <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
        end else if (r_scan_cnt == CNT_LAST) begin
            r_scan_cnt <= '0;
            r_idx      <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    always_comb begin
        w_digit = r_buf[0];
        case (r_idx)
            3'd0: w_digit = r_buf[0];
            3'd1: w_digit = r_buf[1];
            3'd2: w_digit = r_buf[2];
            3'd3: w_digit = r_buf[3];
            3'd4: w_digit = r_buf[4];
            3'd5: w_digit = r_buf[5];
            default: w_digit = r_buf[0];
        endcase
    end

    seg7_decode u_seg7_decode (
        .digit (w_digit),
        .code  (w_seg_code)
    );

    // Outputs lag the index by one cycle so an/seg/dp always switch together
    always_ff @(posedge clk) begin
        if (reset) begin
            seg <= SEG_BLANK;
            dp  <= 1'b1;
            an  <= 6'h3F;
        end else begin
            seg <= w_seg_code;
            dp  <= ~(r_colon_on && ((r_idx == COLON_LO) || (r_idx == COLON_HI)));
            an  <= ~(6'b000001 << r_idx);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_time_display_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_time_display_scan : directed self-checking bench, scan divider of 4   |
// | Revision             : 1.0                                               |
// +--------------------------------------------------------------------------+
module tb_time_display_scan;
    import clock_pkg::*;

    logic       clk;
    logic       reset;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic       update;
    logic       busy;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;

    int errors = 0;
    int checks = 0;

    time_display_scan #(
        .P_HOUR_BIT (5),
        .P_MIN_BIT  (6),
        .P_SEC_BIT  (6),
        .P_SCAN_DIV (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .hour   (hour),
        .minute (minute),
        .second (second),
        .update (update),
        .busy   (busy),
        .seg    (seg),
        .dp     (dp),
        .an     (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [23:0] buf_now();
        return {dut.r_buf[5], dut.r_buf[4], dut.r_buf[3],
                dut.r_buf[2], dut.r_buf[1], dut.r_buf[0]};
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Pulse update and return edges from the sampling edge to the buffer change
    task automatic measure(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                           output int lat);
        logic [23:0] old;
        old    = buf_now();
        hour   = h;
        minute = m;
        second = s;
        update = 1'b1;
        tick();
        update = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            tick();
            if (buf_now() != old) lat = n;
        end
    endtask

    task automatic scan_check(input logic [23:0] digits, input logic colon);
        logic [5:0] prev;
        logic [5:0] e_an;
        logic       e_dp;
        logic       found;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            prev = an;
            tick();
            if (an == 6'h3E && prev != 6'h3E) found = 1'b1;
        end
        chk("scan_sync", {31'd0, found}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            e_an = ~(6'b000001 << i);
            for (int j = 0; j < 4; j++) begin
                if (!(i == 0 && j == 0)) tick();
                chk("an_hold", {26'd0, an}, {26'd0, e_an});
            end
            chk("seg_digit", {25'd0, seg}, {25'd0, seg_code(digits[4*i +: 4])});
            e_dp = (colon && (i == 2 || i == 4)) ? 1'b0 : 1'b1;
            chk("dp", {31'd0, dp}, {31'd0, e_dp});
        end
        tick();
        chk("an_wrap", {26'd0, an}, 32'h3E);
    endtask

    initial begin
        int cnt;
        int lat;
        reset  = 1'b1;
        update = 1'b0;
        hour   = 5'd12;
        minute = 6'd34;
        second = 6'd56;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_an",   {26'd0, an},   32'h3F);
        chk("rst_seg",  {25'd0, seg},  32'h7F);
        chk("rst_dp",   {31'd0, dp},   32'd1);
        chk("rst_buf",  {8'd0, buf_now()}, 32'h0);

        // Automatic conversion after reset: 1 + 2 + 4 + 6 + 1 busy cycles
        reset = 1'b0;
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (busy) cnt++;
            else if (cnt > 0) break;
        end
        chk("boot_busy_cycles", cnt, 14);
        chk("boot_buf", {8'd0, buf_now()}, 32'h123456);
        scan_check(24'h123456, 1'b1);

        measure(5'd23, 6'd59, 6'd59, lat);
        chk("lat_235959", lat, 17);
        chk("buf_235959", {8'd0, buf_now()}, 32'h235959);
        chk("colon_off", {31'd0, dut.r_colon_on}, 32'd0);
        scan_check(24'h235959, 1'b0);

        // Second request arrives mid-conversion as a two-cycle pulse
        hour   = 5'd5;
        minute = 6'd6;
        second = 6'd7;
        update = 1'b1;
        tick();
        update = 1'b0;
        for (int n = 1; n <= 22; n++) begin
            tick();
            if (n == 2) begin
                hour   = 5'd22;
                minute = 6'd33;
                second = 6'd44;
                update = 1'b1;
            end
            if (n == 4) update = 1'b0;
            if (n == 4) chk("first_unchanged", {8'd0, buf_now()}, 32'h235959);
            if (n == 5) begin
                chk("first_commit", {8'd0, buf_now()}, 32'h050607);
                chk("colon_t1", {31'd0, dut.r_colon_on}, 32'd1);
            end
            if (n == 6) chk("second_load", {29'd0, dut.r_state}, {29'd0, ST_LOAD});
            if (n == 19) chk("second_pending", {8'd0, buf_now()}, 32'h050607);
            if (n == 20) begin
                chk("second_commit", {8'd0, buf_now()}, 32'h223344);
                chk("colon_t2", {31'd0, dut.r_colon_on}, 32'd0);
            end
            if (n == 22) chk("collapsed", {31'd0, busy}, 32'd0);
        end

        measure(5'd0, 6'd0, 6'd0, lat);
        chk("lat_000000", lat, 5);
        chk("buf_000000", {8'd0, buf_now()}, 32'h000000);
        scan_check(24'h000000, 1'b1);

        measure(5'd31, 6'd63, 6'd63, lat);
        chk("lat_oor", lat, 20);
        chk("buf_oor", {8'd0, buf_now()}, 32'h316363);
        scan_check(24'h316363, 1'b0);

        // Reset while converting minutes
        hour   = 5'd12;
        minute = 6'd34;
        second = 6'd56;
        update = 1'b1;
        tick();
        update = 1'b0;
        tick();
        tick();
        tick();
        chk("in_conv_m", {29'd0, dut.r_state}, {29'd0, ST_CONV_M});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_an",   {26'd0, an},   32'h3F);
        chk("mid_seg",  {25'd0, seg},  32'h7F);
        chk("mid_buf",  {8'd0, buf_now()}, 32'h0);
        tick();
        chk("restart_busy", {31'd0, busy}, 32'd1);
        wait_idle();
        chk("restart_buf", {8'd0, buf_now()}, 32'h123456);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
